// File: rtl/sys_array_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sys_array_pkg
// Brief    : Shared state encodings and width helpers for the array sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package sys_array_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CLR  = 3'd1;
  localparam logic [2:0] ST_FEED = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_WAIT = 3'd4;
  localparam logic [2:0] ST_HOLD = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_CLR  = ST_CLR,
    S_FEED = ST_FEED,
    S_DONE = ST_DONE,
    S_WAIT = ST_WAIT,
    S_HOLD = ST_HOLD
  } seq_state_e;

  function automatic int a_width(input int sys_h, input int arr_h, input int w);
    return sys_h * arr_h * w;
  endfunction

  function automatic int b_width(input int sys_w, input int arr_w, input int w);
    return sys_w * arr_w * w;
  endfunction

  function automatic int c_width(input int sys_h, input int arr_h, input int sys_w,
                                 input int arr_w, input int w);
    return sys_h * arr_h * sys_w * arr_w * w;
  endfunction

  function automatic int k_width(input int k_max);
    return $clog2(k_max + 1);
  endfunction

  function automatic int t_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sys_seq_timeout.sv
`default_nettype none
// ============================================================================
// Module   : sys_seq_timeout
// Brief    : Loadable saturating up-counter with clear and terminal-count flag.
// Revision : 1.0 - initial release
// ============================================================================
module sys_seq_timeout #(
  parameter int LIMIT = 1024,
  parameter int CNTW  = $clog2(LIMIT + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            load,
  input  logic [CNTW-1:0] load_val,
  input  logic            en,
  output logic            expired
);

  localparam logic [CNTW-1:0] c_limit = CNTW'(LIMIT);
  localparam logic [CNTW-1:0] c_last  = CNTW'(LIMIT - 1);

  logic [CNTW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en && (r_count != c_limit)) begin
      r_count <= r_count + CNTW'(1);
    end
  end

  // Flags the enabled cycle whose increment would reach LIMIT.
  assign expired = en && (r_count >= c_last);

endmodule
`default_nettype wire

// File: rtl/sys_array_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sys_array_sequencer
// Brief    : Command-driven operand feeder and per-tile result collector for
//            the NDP_unit systolic array.
// Revision : 1.0 - initial release
// ============================================================================
module sys_array_sequencer
  import sys_array_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ARR_HEIGHT = 4,
  parameter int ARR_WIDTH  = 4,
  parameter int SYS_HEIGHT = 1,
  parameter int SYS_WIDTH  = 64,
  parameter int K_MAX      = 256,
  parameter int TIMEOUT    = 1024
) (
  input  logic                                                    clk,
  input  logic                                                    reset,
  input  logic                                                    cmd_valid,
  output logic                                                    cmd_ready,
  input  logic [k_width(K_MAX)-1:0]                               cmd_k,
  input  logic [7:0]                                              cmd_tiles,
  input  logic [1:0]                                              cmd_simd,
  input  logic                                                    op_valid,
  output logic                                                    op_ready,
  input  logic [a_width(SYS_HEIGHT, ARR_HEIGHT, WIDTH)-1:0]       op_a,
  input  logic [b_width(SYS_WIDTH, ARR_WIDTH, WIDTH)-1:0]         op_b,
  output logic [a_width(SYS_HEIGHT, ARR_HEIGHT, WIDTH)-1:0]       arr_in_a,
  output logic [b_width(SYS_WIDTH, ARR_WIDTH, WIDTH)-1:0]         arr_in_b,
  output logic                                                    arr_in_done,
  output logic                                                    arr_reset,
  output logic [1:0]                                              arr_simd,
  input  logic                                                    arr_calc_done,
  input  logic [c_width(SYS_HEIGHT, ARR_HEIGHT, SYS_WIDTH, ARR_WIDTH, WIDTH)-1:0] arr_out_c,
  output logic                                                    res_valid,
  input  logic                                                    res_ready,
  output logic [c_width(SYS_HEIGHT, ARR_HEIGHT, SYS_WIDTH, ARR_WIDTH, WIDTH)-1:0] res_data,
  output logic [7:0]                                              res_tile,
  output logic                                                    res_last,
  output logic                                                    busy,
  output logic                                                    err_badcmd,
  output logic                                                    err_timeout
);

  localparam int AW = a_width(SYS_HEIGHT, ARR_HEIGHT, WIDTH);
  localparam int BW = b_width(SYS_WIDTH, ARR_WIDTH, WIDTH);
  localparam int CW = c_width(SYS_HEIGHT, ARR_HEIGHT, SYS_WIDTH, ARR_WIDTH, WIDTH);
  localparam int KW = k_width(K_MAX);
  localparam int TW = t_width(TIMEOUT);

  localparam logic [KW-1:0] c_k_max = KW'(K_MAX);

  seq_state_e     r_state;
  seq_state_e     w_next;
  logic [KW-1:0]  r_k;
  logic [KW-1:0]  r_beat_cnt;
  logic [7:0]     r_tiles;
  logic [7:0]     r_tile_idx;
  logic [1:0]     r_simd;
  logic [AW-1:0]  r_arr_a;
  logic [BW-1:0]  r_arr_b;
  logic           r_in_done;
  logic           r_res_valid;
  logic [CW-1:0]  r_res_data;
  logic [7:0]     r_res_tile;
  logic           r_err_badcmd;
  logic           r_err_timeout;

  logic w_cmd_bad;
  logic w_last_beat;
  logic w_res_last;
  logic w_expired;
  logic w_to_clr;
  logic w_to_en;

  assign w_cmd_bad   = (cmd_k == '0) || (cmd_k > c_k_max) || (cmd_tiles == '0);
  assign w_last_beat = (r_beat_cnt == (r_k - KW'(1)));
  assign w_res_last  = (r_res_tile == (r_tiles - 8'd1));
  assign w_to_clr    = (r_state == S_DONE);
  assign w_to_en     = (r_state == S_WAIT);

  sys_seq_timeout #(
    .LIMIT (TIMEOUT),
    .CNTW  (TW)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (reset),
    .clr      (w_to_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (w_to_en),
    .expired  (w_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    op_ready  = 1'b0;
    busy      = (r_state != S_IDLE);
    // The array is held in reset along with the sequencer.
    arr_reset = (r_state == S_CLR) || !reset;
    case (r_state)
      S_IDLE: begin
        cmd_ready = reset;
        if (cmd_valid && !w_cmd_bad) w_next = S_CLR;
      end
      S_CLR:  w_next = S_FEED;
      S_FEED: begin
        op_ready = 1'b1;
        if (op_valid && w_last_beat) w_next = S_DONE;
      end
      S_DONE: w_next = S_WAIT;
      S_WAIT: begin
        if (arr_calc_done)  w_next = S_HOLD;
        else if (w_expired) w_next = S_IDLE;
      end
      S_HOLD: begin
        if (res_ready) w_next = w_res_last ? S_IDLE : S_CLR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_k           <= '0;
      r_beat_cnt    <= '0;
      r_tiles       <= '0;
      r_tile_idx    <= '0;
      r_simd        <= '0;
      r_arr_a       <= '0;
      r_arr_b       <= '0;
      r_in_done     <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_data    <= '0;
      r_res_tile    <= '0;
      r_err_badcmd  <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_err_badcmd <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (w_cmd_bad) begin
              r_err_badcmd <= 1'b1;
            end else begin
              r_k        <= cmd_k;
              r_tiles    <= cmd_tiles;
              r_simd     <= cmd_simd;
              r_tile_idx <= '0;
            end
          end
        end
        S_CLR: r_beat_cnt <= '0;
        S_FEED: begin
          // Bubbles present zero vectors, which leave every dot product unchanged.
          r_arr_a <= op_valid ? op_a : '0;
          r_arr_b <= op_valid ? op_b : '0;
          if (op_valid) r_beat_cnt <= r_beat_cnt + KW'(1);
        end
        S_DONE: begin
          r_arr_a   <= '0;
          r_arr_b   <= '0;
          r_in_done <= 1'b1;
        end
        S_WAIT: begin
          // A result arriving in the expiry cycle still wins over the timeout.
          if (arr_calc_done) begin
            r_res_data  <= arr_out_c;
            r_res_tile  <= r_tile_idx;
            r_res_valid <= 1'b1;
            r_in_done   <= 1'b0;
          end else if (w_expired) begin
            r_err_timeout <= 1'b1;
            r_in_done     <= 1'b0;
          end
        end
        S_HOLD: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            if (!w_res_last) r_tile_idx <= r_tile_idx + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign arr_in_a    = r_arr_a;
  assign arr_in_b    = r_arr_b;
  assign arr_in_done = r_in_done;
  assign arr_simd    = r_simd;
  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;
  assign res_tile    = r_res_tile;
  assign res_last    = w_res_last;
  assign err_badcmd  = r_err_badcmd;
  assign err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_sys_array_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sys_array_sequencer
// Brief    : Directed self-checking bench with a behavioural array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sys_array_sequencer;

  localparam int WIDTH   = 16;
  localparam int ARR_H   = 4;
  localparam int ARR_W   = 4;
  localparam int SYS_H   = 1;
  localparam int SYS_W   = 2;
  localparam int K_MAX   = 8;
  localparam int TIMEOUT = 16;
  localparam int NR      = SYS_H * ARR_H;
  localparam int NC      = SYS_W * ARR_W;
  localparam int AW      = NR * WIDTH;
  localparam int BW      = NC * WIDTH;
  localparam int CW      = NR * NC * WIDTH;
  localparam int KW      = $clog2(K_MAX + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [KW-1:0] cmd_k;
  logic [7:0]    cmd_tiles;
  logic [1:0]    cmd_simd;
  logic          op_valid;
  logic          op_ready;
  logic [AW-1:0] op_a;
  logic [BW-1:0] op_b;
  logic [AW-1:0] arr_in_a;
  logic [BW-1:0] arr_in_b;
  logic          arr_in_done;
  logic          arr_reset;
  logic [1:0]    arr_simd;
  logic          arr_calc_done;
  logic [CW-1:0] arr_out_c;
  logic          res_valid;
  logic          res_ready;
  logic [CW-1:0] res_data;
  logic [7:0]    res_tile;
  logic          res_last;
  logic          busy;
  logic          err_badcmd;
  logic          err_timeout;

  int n_checks = 0;
  int n_errors = 0;
  int rst_pulses = 0;
  int resp_delay = 8;

  always #5 clk = ~clk;

  sys_array_sequencer #(
    .WIDTH(WIDTH), .ARR_HEIGHT(ARR_H), .ARR_WIDTH(ARR_W),
    .SYS_HEIGHT(SYS_H), .SYS_WIDTH(SYS_W), .K_MAX(K_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_k(cmd_k),
    .cmd_tiles(cmd_tiles), .cmd_simd(cmd_simd),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .arr_in_a(arr_in_a), .arr_in_b(arr_in_b), .arr_in_done(arr_in_done),
    .arr_reset(arr_reset), .arr_simd(arr_simd),
    .arr_calc_done(arr_calc_done), .arr_out_c(arr_out_c),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tile(res_tile), .res_last(res_last), .busy(busy),
    .err_badcmd(err_badcmd), .err_timeout(err_timeout)
  );

  // Array model: outer-product accumulation mod 2^16, done after resp_delay cycles.
  logic [WIDTH-1:0] acc [NR][NC];
  int done_cnt;

  always @(posedge clk) begin
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < NC; j++)
        acc[i][j] <= arr_reset ? '0 :
                     acc[i][j] + arr_in_a[i*WIDTH +: WIDTH] * arr_in_b[j*WIDTH +: WIDTH];
    arr_calc_done <= 1'b0;
    if (!arr_in_done) begin
      done_cnt <= 0;
    end else begin
      done_cnt <= done_cnt + 1;
      if (resp_delay >= 0 && done_cnt == resp_delay - 1) arr_calc_done <= 1'b1;
    end
  end

  always_comb begin
    arr_out_c = '0;
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < NC; j++)
        arr_out_c[(i*NC + j)*WIDTH +: WIDTH] = acc[i][j];
  end

  always @(negedge clk) if (reset && arr_reset) rst_pulses++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] mk_a(input int vs, input int b);
    logic [AW-1:0] r;
    for (int i = 0; i < NR; i++) r[i*WIDTH +: WIDTH] = 16'(vs*101 + b*7 + i*3 + 1);
    return r;
  endfunction

  function automatic logic [BW-1:0] mk_b(input int vs, input int b);
    logic [BW-1:0] r;
    for (int j = 0; j < NC; j++) r[j*WIDTH +: WIDTH] = 16'(vs*53 + b*11 + j*5 + 2);
    return r;
  endfunction

  function automatic logic [CW-1:0] gold(input int vs, input int k);
    logic [CW-1:0]    r;
    logic [AW-1:0]    a;
    logic [BW-1:0]    bb;
    logic [WIDTH-1:0] s;
    r = '0;
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < NC; j++) begin
        s = '0;
        for (int x = 0; x < k; x++) begin
          a  = mk_a(vs, x);
          bb = mk_b(vs, x);
          s  = s + a[i*WIDTH +: WIDTH] * bb[j*WIDTH +: WIDTH];
        end
        r[(i*NC + j)*WIDTH +: WIDTH] = s;
      end
    return r;
  endfunction

  task automatic send_cmd(input int k, input int tiles, input logic [1:0] simd);
    cmd_valid = 1'b1;
    cmd_k     = KW'(k);
    cmd_tiles = 8'(tiles);
    cmd_simd  = simd;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic feed(input int vs, input bit bubbles, input int nb, output int cycles);
    int b = 0;
    bit v = 1'b1;
    bit hs;
    cycles = 0;
    while (b < nb && cycles < 100) begin
      op_valid = v;
      op_a     = mk_a(vs, b);
      op_b     = mk_b(vs, b);
      hs       = v && op_ready;
      @(posedge clk);
      @(negedge clk);
      if (hs) b++;
      cycles++;
      if (bubbles) v = ~v;
    end
    op_valid = 1'b0;
    op_a     = '0;
    op_b     = '0;
    if (b < nb) check("feed_stalled", 32'(b), 32'(nb));
  endtask

  task automatic get_result(input int vs, input int k, input int exp_tile,
                            input bit exp_last, input int hold);
    int  n = 0;
    bit  prev_cd = 1'b0;
    while (!res_valid && n < 60) begin
      prev_cd = arr_calc_done;
      @(negedge clk);
      n++;
    end
    if (!res_valid) begin
      check("res_valid_wait", 1'b0, 1'b1);
    end else begin
      check("res_after_calc_done", prev_cd, 1'b1);
      check("res_data", res_data, gold(vs, k));
      check("res_tile", res_tile, 8'(exp_tile));
      check("res_last", res_last, exp_last);
      repeat (hold) @(negedge clk);
      check("res_valid_held", res_valid, 1'b1);
      check("res_data_held", res_data, gold(vs, k));
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      res_ready = 1'b0;
      check("res_valid_drop", res_valid, 1'b0);
    end
  endtask

  initial begin
    int cyc;
    int p0;
    int n;
    bit saw_rv;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_k     = '0;
    cmd_tiles = '0;
    cmd_simd  = '0;
    op_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    res_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_arr_reset", arr_reset, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_in_done", arr_in_done, 1'b0);
    check("rst_err", {err_badcmd, err_timeout}, 2'b00);
    check("rst_res_data", res_data, '0);
    reset = 1'b1;
    @(negedge clk);
    check("cmd_ready_after_rst", cmd_ready, 1'b1);
    check("arr_reset_after_rst", arr_reset, 1'b0);

    // Single tile, operands always valid.
    p0 = rst_pulses;
    send_cmd(5, 1, 2'd2);
    check("clr_arr_reset", arr_reset, 1'b1);
    check("clr_op_ready", op_ready, 1'b0);
    check("arr_simd", arr_simd, 2'd2);
    feed(0, 1'b0, 5, cyc);
    check("feed_cycles", 32'(cyc), 32'd6);
    check("last_beat_on_bus", arr_in_a, mk_a(0, 4));
    check("in_done_after_last", arr_in_done, 1'b0);
    @(negedge clk);
    check("in_done_rise", arr_in_done, 1'b1);
    check("in_a_zero_in_wait", arr_in_a, '0);
    get_result(0, 5, 0, 1'b1, 0);
    check("cmd_ready_after_res", cmd_ready, 1'b1);
    check("single_clr_pulses", 32'(rst_pulses - p0), 32'd1);

    // Three tiles, operand bubbles and result backpressure.
    p0 = rst_pulses;
    send_cmd(5, 3, 2'd1);
    for (int t = 0; t < 3; t++) begin
      feed(t + 1, 1'b1, 5, cyc);
      get_result(t + 1, 5, t, t == 2, 4);
    end
    check("multi_clr_pulses", 32'(rst_pulses - p0), 32'd3);
    check("multi_idle", busy, 1'b0);

    // Rejected commands.
    p0 = rst_pulses;
    for (int c = 0; c < 3; c++) begin
      cmd_valid = 1'b1;
      cmd_k     = (c == 0) ? KW'(0) : (c == 1) ? KW'(K_MAX + 1) : KW'(3);
      cmd_tiles = (c == 2) ? 8'd0 : 8'd1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("badcmd_pulse", err_badcmd, 1'b1);
      check("badcmd_busy", busy, 1'b0);
      @(negedge clk);
      check("badcmd_single", err_badcmd, 1'b0);
    end
    check("badcmd_no_clr", 32'(rst_pulses - p0), 32'd0);

    // Result arriving in the same cycle the timeout expires.
    resp_delay = 15;
    send_cmd(3, 1, 2'd0);
    feed(4, 1'b0, 3, cyc);
    get_result(4, 3, 0, 1'b1, 0);
    check("tie_no_timeout", err_timeout, 1'b0);
    resp_delay = 8;

    // Reset in the middle of feeding, then a clean command.
    send_cmd(5, 1, 2'd3);
    feed(5, 1'b0, 3, cyc);
    reset = 1'b0;
    #1;
    check("midrst_arr_reset", arr_reset, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_cmd_ready", cmd_ready, 1'b0);
    check("midrst_in_a", arr_in_a, '0);
    check("midrst_simd", arr_simd, 2'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send_cmd(5, 1, 2'd0);
    feed(6, 1'b0, 5, cyc);
    get_result(6, 5, 0, 1'b1, 0);

    // Array never answers.
    resp_delay = -1;
    send_cmd(2, 2, 2'd0);
    feed(7, 1'b0, 2, cyc);
    n = 0;
    while (!arr_in_done && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("timeout_in_done", arr_in_done, 1'b1);
    n = 0;
    saw_rv = 1'b0;
    while (!err_timeout && n < 40) begin
      if (res_valid) saw_rv = 1'b1;
      @(negedge clk);
      n++;
    end
    check("timeout_latency", 32'(n), 32'd16);
    check("timeout_no_result", saw_rv, 1'b0);
    check("timeout_idle", cmd_ready, 1'b1);
    repeat (5) @(negedge clk);
    check("timeout_sticky", err_timeout, 1'b1);
    check("timeout_res_valid", res_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
